// File: rtl/router_src_ingress.sv
// Source-side ingress for a packet router: frames header/payload/parity words,
// checks parity and length, drops packets for illegal destinations and queues
// accepted words with per-entry sideband (dest, sof, eof, err) in a FIFO.
module router_src_ingress #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned N_CHAN = 3,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pkt_valid,
    output logic              busy,
    output logic              error,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_dest,
    output logic              out_sof,
    output logic              out_eof,
    output logic              out_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       drop_cnt
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned LenW = DATA_W - ADDR_W;
    localparam int unsigned EntW = DATA_W + ADDR_W + 3;
    localparam logic [ADDR_W:0] NChan = N_CHAN[ADDR_W:0];
    localparam logic [CntW-1:0] Full  = CntW'(DEPTH);

    typedef enum logic [1:0] {StSync, StIdle, StLoad, StDrop} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] dest_q, dest_d;
    logic [LenW-1:0]   len_q, len_d;
    logic [DATA_W-1:0] par_q, par_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              error_q, error_d;
    logic [15:0]       drop_q, drop_d;

    logic [EntW-1:0]   mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [EntW-1:0]   head_q, head_d;

    logic              wr_en, wr_sof, wr_eof, wr_err, rd_en;
    logic [ADDR_W-1:0] wr_dest, hdr_dest;
    logic [EntW-1:0]   wr_word;

    assign hdr_dest = data_in[ADDR_W-1:0];
    assign wr_word  = {wr_err, wr_eof, wr_sof, wr_dest, data_in};

    // No pass-through: a read in the same cycle does not release a full FIFO.
    assign busy      = (count_q == Full) && ((state_q == StIdle) || (state_q == StLoad));
    assign out_valid = (count_q != '0);
    assign rd_en     = out_valid && out_ready;
    assign error     = error_q;
    assign drop_cnt  = drop_q;
    assign {out_err, out_eof, out_sof, out_dest, out_data} = head_q;

    // Framing FSM: next state, packet bookkeeping and FIFO write request.
    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        len_d   = len_q;
        par_d   = par_q;
        cnt_d   = cnt_q;
        error_d = error_q;
        drop_d  = drop_q;
        wr_en   = 1'b0;
        wr_sof  = 1'b0;
        wr_eof  = 1'b0;
        wr_err  = 1'b0;
        wr_dest = dest_q;
        unique case (state_q)
            StSync: begin
                if (!pkt_valid) state_d = StIdle;
            end
            StIdle: begin
                if (pkt_valid && !busy) begin
                    error_d = 1'b0;
                    if ({1'b0, hdr_dest} < NChan) begin
                        wr_en   = 1'b1;
                        wr_sof  = 1'b1;
                        wr_dest = hdr_dest;
                        dest_d  = hdr_dest;
                        len_d   = data_in[DATA_W-1:ADDR_W];
                        par_d   = data_in;
                        cnt_d   = '0;
                        state_d = StLoad;
                    end else begin
                        state_d = StDrop;
                    end
                end
            end
            StLoad: begin
                if (!busy) begin
                    wr_en = 1'b1;
                    if (pkt_valid) begin
                        par_d = par_q ^ data_in;
                        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                    end else begin
                        wr_eof  = 1'b1;
                        wr_err  = (par_q != data_in) || (cnt_q != 16'(len_q));
                        error_d = wr_err;
                        state_d = StIdle;
                    end
                end
            end
            StDrop: begin
                if (!pkt_valid) begin
                    state_d = StIdle;
                    if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
                end
            end
            default: state_d = StSync;
        endcase
    end

    // FIFO pointers, occupancy and the registered head word.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PtrW'(wr_en);
        rd_ptr_d = rd_ptr_q + PtrW'(rd_en);
        count_d  = count_q + CntW'(wr_en) - CntW'(rd_en);
        head_d   = head_q;
        // When empty, head holds its last value so out_* stay stable.
        if (count_d != '0) begin
            if (count_q == CntW'(rd_en)) head_d = wr_word;
            else                         head_d = mem_q[rd_ptr_d];
        end
    end

    // State and control registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StSync;
            dest_q   <= '0;
            len_q    <= '0;
            par_q    <= '0;
            cnt_q    <= '0;
            error_q  <= 1'b0;
            drop_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            state_q  <= state_d;
            dest_q   <= dest_d;
            len_q    <= len_d;
            par_q    <= par_d;
            cnt_q    <= cnt_d;
            error_q  <= error_d;
            drop_q   <= drop_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    // FIFO storage; contents need no reset since pointers gate visibility.
    always_ff @(posedge clock) begin
        if (!reset && wr_en) mem_q[wr_ptr_q] <= wr_word;
    end

endmodule

// File: tb/tb_router_src_ingress.sv
// Self-checking bench for router_src_ingress: table of directed packets,
// hand-written backpressure and reset sequences, then random packets checked
// against a queue-based reference model.
module tb_router_src_ingress;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;
    localparam int N_CHAN = 3;
    localparam int DEPTH  = 16;

    logic              clock = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] data_in;
    logic              pkt_valid;
    logic              busy, error;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_dest;
    logic              out_sof, out_eof, out_err, out_valid;
    logic              out_ready;
    logic [15:0]       drop_cnt;

    router_src_ingress #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_CHAN(N_CHAN), .DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .data_in(data_in), .pkt_valid(pkt_valid),
        .busy(busy), .error(error), .out_data(out_data), .out_dest(out_dest),
        .out_sof(out_sof), .out_eof(out_eof), .out_err(out_err),
        .out_valid(out_valid), .out_ready(out_ready), .drop_cnt(drop_cnt)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] dest;
        logic       sof;
        logic       eof;
        logic       err;
    } word_t;

    typedef struct {
        logic [7:0] hdr;
        int         npay;
        logic [7:0] pay [4];
        logic [7:0] flip;
        logic       exp_err;
        int         exp_drop;
    } vec_t;

    word_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    exp_drops = 0;
    int    ready_mode = 0;  // 0: stall, 1: always ready, 2: random
    int    stall_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_ready(input int mode);
        ready_mode = mode;
        out_ready  = (mode == 1);
    endtask

    always @(posedge clock) begin
        #1;
        out_ready = (ready_mode == 1) || (ready_mode == 2 && $urandom_range(0, 1) == 1);
    end

    // Sink-side monitor: every accepted word must be the next one the model expects.
    always @(negedge clock) begin : mon
        word_t got;
        if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            got = '{out_data, out_dest, out_sof, out_eof, out_err};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %0h expected none", got);
            end else begin
                check("out_word", 32'(got), 32'(exp_q.pop_front()));
            end
        end
    end

    // Present one word; hold it while busy, return 1ns after the accepting edge.
    task automatic put(input logic [7:0] d, input logic v);
        int n = 0;
        data_in   = d;
        pkt_valid = v;
        @(negedge clock);
        while (busy === 1'b1 && n < 2000) begin
            stall_cnt++;
            n++;
            @(negedge clock);
        end
        if (busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL put_timeout: busy %b expected 0", busy);
        end
        @(posedge clock);
        #1;
    endtask

    // Reference model: expected words / error / drop count from the packet rules.
    task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] pay[$],
                            input logic [7:0] flip, input string tag);
        logic [7:0] x;
        logic [7:0] parity;
        logic [1:0] dest;
        int         len;
        bit         drop;
        bit         err;
        x    = hdr;
        dest = hdr[1:0];
        len  = int'(hdr[7:2]);
        foreach (pay[i]) x ^= pay[i];
        parity = x ^ flip;
        drop = (int'(dest) >= N_CHAN);
        err  = (flip != 8'h00) || (pay.size() != len);
        if (!drop) begin
            exp_q.push_back('{hdr, dest, 1'b1, 1'b0, 1'b0});
            foreach (pay[i]) exp_q.push_back('{pay[i], dest, 1'b0, 1'b0, 1'b0});
            exp_q.push_back('{parity, dest, 1'b0, 1'b1, err});
        end else begin
            exp_drops++;
        end
        stall_cnt = 0;
        put(hdr, 1'b1);
        check({tag, " error_clr"}, 32'(error), 32'(0));
        foreach (pay[i]) put(pay[i], 1'b1);
        put(parity, 1'b0);
        check({tag, " error"}, 32'(error), 32'(drop ? 1'b0 : err));
        check({tag, " drop_cnt"}, 32'(drop_cnt), 32'(exp_drops));
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        check({tag, " drained"}, 32'(exp_q.size()), 32'(0));
        check({tag, " empty"}, 32'(out_valid), 32'(0));
        @(posedge clock);
        #1;
    endtask

    initial begin
        vec_t       vecs [7];
        logic [7:0] q[$];
        logic [7:0] big[$];
        int         prev;

        vecs[0] = '{8'h0D, 3, '{8'h11, 8'h22, 8'h33, 8'h00}, 8'h00, 1'b0, 0};
        vecs[1] = '{8'h0D, 3, '{8'h11, 8'h22, 8'h33, 8'h00}, 8'h01, 1'b1, 0};
        vecs[2] = '{8'h03, 2, '{8'h44, 8'h55, 8'h00, 8'h00}, 8'h00, 1'b0, 1};
        vecs[3] = '{8'h12, 3, '{8'h01, 8'h02, 8'h03, 8'h00}, 8'h00, 1'b1, 0};
        vecs[4] = '{8'h08, 2, '{8'hA0, 8'hB1, 8'h00, 8'h00}, 8'h00, 1'b0, 0};
        vecs[5] = '{8'h00, 0, '{8'h00, 8'h00, 8'h00, 8'h00}, 8'h00, 1'b0, 0};
        vecs[6] = '{8'h0F, 0, '{8'h00, 8'h00, 8'h00, 8'h00}, 8'h00, 1'b0, 1};

        // Reset values.
        reset = 1'b1;
        pkt_valid = 1'b0;
        data_in = 8'h00;
        set_ready(0);
        repeat (3) @(posedge clock);
        #1;
        check("rst busy", 32'(busy), 32'(0));
        check("rst error", 32'(error), 32'(0));
        check("rst out_valid", 32'(out_valid), 32'(0));
        check("rst sof/eof/err", 32'({out_sof, out_eof, out_err}), 32'(0));
        check("rst out_data", 32'(out_data), 32'(0));
        check("rst out_dest", 32'(out_dest), 32'(0));
        check("rst drop_cnt", 32'(drop_cnt), 32'(0));
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // Directed table.
        set_ready(1);
        for (int v = 0; v < 7; v++) begin
            q.delete();
            for (int i = 0; i < vecs[v].npay; i++) q.push_back(vecs[v].pay[i]);
            prev = exp_drops;
            send_pkt(vecs[v].hdr, q, vecs[v].flip, $sformatf("vec%0d", v));
            check($sformatf("vec%0d tbl_error", v), 32'(error), 32'(vecs[v].exp_err));
            check($sformatf("vec%0d tbl_drop", v), 32'(drop_cnt), 32'(prev + vecs[v].exp_drop));
            if (vecs[v].exp_drop != 0)
                check($sformatf("vec%0d drop_no_busy", v), 32'(stall_cnt), 32'(0));
            drain($sformatf("vec%0d", v));
        end

        // Backpressure: 20-word packet into a 16-deep FIFO with the sink stalled.
        set_ready(0);
        big.delete();
        for (int i = 0; i < 20; i++) big.push_back(8'($urandom_range(0, 255)));
        fork
            send_pkt(8'h51, big, 8'h00, "bp");
            begin
                repeat (30) @(negedge clock);
                check("bp busy_full", 32'(busy), 32'(1));
                check("bp head_valid", 32'(out_valid), 32'(1));
                check("bp head_sof", 32'(out_sof), 32'(1));
                set_ready(1);
            end
        join
        check("bp stalled", 32'(stall_cnt > 0), 32'(1));
        drain("bp");

        // Reset after two payload words while pkt_valid stays high.
        set_ready(0);
        put(8'h0D, 1'b1);
        put(8'h11, 1'b1);
        put(8'h22, 1'b1);
        data_in = 8'h33;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_q.delete();
        exp_drops = 0;
        check("mid_rst out_valid", 32'(out_valid), 32'(0));
        check("mid_rst out_data", 32'(out_data), 32'(0));
        check("mid_rst drop_cnt", 32'(drop_cnt), 32'(0));
        data_in = 8'h04;
        @(posedge clock);
        #1;
        data_in = 8'h05;
        @(posedge clock);
        #1;
        pkt_valid = 1'b0;
        data_in = 8'hAA;
        @(posedge clock);
        #1;
        set_ready(1);
        repeat (3) @(posedge clock);
        #1;
        check("mid_rst no_output", 32'(out_valid), 32'(0));
        q.delete();
        q.push_back(8'h11);
        q.push_back(8'h22);
        q.push_back(8'h33);
        send_pkt(8'h0D, q, 8'h00, "post_rst");
        drain("post_rst");

        // Random packets against the model with a randomly ready sink.
        set_ready(2);
        for (int k = 0; k < 30; k++) begin
            int n;
            int len;
            int dest;
            logic [7:0] flip;
            n    = $urandom_range(0, 6);
            dest = $urandom_range(0, 3);
            len  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : n;
            flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            q.delete();
            for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
            send_pkt({6'(len), 2'(dest)}, q, flip, $sformatf("rnd%0d", k));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock);
                #1;
            end
        end
        drain("rnd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
